mod_mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one 256-bit modular multiplier (`multiplier`, modulus `params.n`) among NREQ requesters, such as point-add and point-double units. It latches the winning requester's operands and starts the multiplier by pulsing its Reset. It then waits for Done, returns the product to the owner with a one-cycle done pulse, and guards every operation with a watchdog.

---
 rtl/mod_arith_pkg.sv | 24 ++
 rtl/mod_mult_arbiter_rr.sv | 31 +++
 rtl/mod_mult_arbiter.sv | 141 ++++++++++++++
 tb/tb_mod_mult_arbiter.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mod_arith_pkg.sv
// Shared constants and types for the modular-arithmetic datapath.
// Holds the multiplier width, the P-256 field modulus and the arbiter state encoding.
package mod_arith_pkg;

  localparam int WIDTH       = 256;
  localparam int TIMEOUT_DEF = 2048;

  // Field modulus used by the shared multiplier (NIST P-256 prime).
  localparam logic [WIDTH-1:0] N_MOD =
    256'hFFFFFFFF_00000001_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_e;

  // Round-robin successor of a requester index.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/mod_mult_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   pointer,
  output logic [NREQ-1:0] grant_onehot,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  // Scan from the pointer with wrap; only the first hit is recorded.
  always_comb begin
    int  w_k;
    logic w_hit;
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    w_k          = 0;
    w_hit        = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_k               = (int'(pointer) + i) % NREQ;
      w_hit             = !any && req[w_k];
      grant_onehot[w_k] = grant_onehot[w_k] | w_hit;
      grant_idx         = w_hit ? IW'(w_k) : grant_idx;
      any               = any | req[w_k];
    end
  end

endmodule

// File: rtl/mod_mult_arbiter.sv
// Shares one modular multiplier among NREQ requesters: arbitrate, launch, wait with
// watchdog, and return the product to the owner with a one-cycle done pulse.
module mod_mult_arbiter
  import mod_arith_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = mod_arith_pkg::WIDTH,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                       clk,
  input  logic                       Reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][WIDTH-1:0] a_i,
  input  logic [NREQ-1:0][WIDTH-1:0] b_i,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            done,
  output logic                       err,
  output logic [WIDTH-1:0]           product,
  output logic                       mul_reset,
  output logic [WIDTH-1:0]           mul_a,
  output logic [WIDTH-1:0]           mul_b,
  input  logic                       mul_done,
  input  logic [WIDTH-1:0]           mul_product
);

  localparam int IW  = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT) + 1;

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [NREQ-1:0]  r_gnt;
  logic [NREQ-1:0]  r_done;
  logic             r_err;
  logic [IW-1:0]    r_pointer;
  logic [IW-1:0]    r_owner;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_product;
  logic [WDW-1:0]   r_wd;

  logic [NREQ-1:0]  w_grant_onehot;
  logic [IW-1:0]    w_grant_idx;
  logic             w_any;
  logic             w_timeout;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rr (
    .req          (req),
    .pointer      (r_pointer),
    .grant_onehot (w_grant_onehot),
    .grant_idx    (w_grant_idx),
    .any          (w_any)
  );

  assign w_timeout = (r_wd == WDW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; mul_done only matters while waiting.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_state_nxt = ST_LAUNCH;
        else       w_state_nxt = ST_IDLE;
      end
      ST_LAUNCH: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (mul_done)       w_state_nxt = ST_RESP;
        else if (w_timeout) w_state_nxt = ST_RESP;
        else                w_state_nxt = ST_WAIT;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant, operand latches, watchdog, pointer and response registers.
  always_ff @(posedge clk) begin
    if (Reset) begin
      r_gnt     <= '0;
      r_done    <= '0;
      r_err     <= 1'b0;
      r_pointer <= '0;
      r_owner   <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_product <= '0;
      r_wd      <= '0;
    end else begin
      r_done <= '0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt   <= w_grant_onehot;
            r_owner <= w_grant_idx;
            r_op_a  <= a_i[w_grant_idx];
            r_op_b  <= b_i[w_grant_idx];
            r_wd    <= '0;
          end
        end
        ST_WAIT: begin
          r_wd <= r_wd + WDW'(1);
          if (mul_done) begin
            r_product <= mul_product;
            r_done    <= r_gnt;
            r_err     <= 1'b0;
          end else if (w_timeout) begin
            r_product <= '0;
            r_done    <= r_gnt;
            r_err     <= 1'b1;
          end
        end
        ST_RESP: begin
          r_pointer <= IW'(rr_next(32'(r_owner), NREQ));
          r_gnt     <= '0;
        end
        default: begin
          r_gnt <= r_gnt;
        end
      endcase
    end
  end

  // The LAUNCH pulse also clears any Done left over from the previous operation.
  assign mul_reset = Reset | (r_state == ST_LAUNCH);
  assign mul_a     = r_op_a;
  assign mul_b     = r_op_b;
  assign gnt       = r_gnt;
  assign done      = r_done;
  assign err       = r_err;
  assign product   = r_product;

endmodule

// File: tb/tb_mod_mult_arbiter.sv
// Directed bench for mod_mult_arbiter with a behavioural multiplier stub
// (programmable Done latency, Done held until reset, optional never-done).
module tb_mod_mult_arbiter;
  import mod_arith_pkg::*;

  localparam int NREQ = 4;
  localparam int TO   = 16;

  logic                  clk = 1'b0;
  logic                  Reset;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0][255:0] a_i;
  logic [NREQ-1:0][255:0] b_i;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       done;
  logic                  err;
  logic [255:0]          product;
  logic                  mul_reset;
  logic [255:0]          mul_a;
  logic [255:0]          mul_b;
  logic                  mul_done;
  logic [255:0]          mul_product;

  int           stub_lat   = 3;
  bit           stub_never = 1'b0;
  int           st_cnt     = 0;
  logic         st_done    = 1'b0;
  logic [255:0] st_prod    = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mod_mult_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .req         (req),
    .a_i         (a_i),
    .b_i         (b_i),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .product     (product),
    .mul_reset   (mul_reset),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_done    (mul_done),
    .mul_product (mul_product)
  );

  function automatic logic [255:0] modmul(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] p;
    p = {256'd0, a} * {256'd0, b};
    p = p % {256'd0, N_MOD};
    return p[255:0];
  endfunction

  // Multiplier stub: Reset clears it, Done rises after stub_lat cycles and stays high.
  always_ff @(posedge clk) begin
    if (mul_reset) begin
      st_cnt  <= 0;
      st_done <= 1'b0;
    end else if (!st_done && !stub_never) begin
      if (st_cnt >= stub_lat - 1) begin
        st_done <= 1'b1;
        st_prod <= modmul(mul_a, mul_b);
      end else begin
        st_cnt <= st_cnt + 1;
      end
    end
  end

  assign mul_done    = st_done;
  assign mul_product = st_prod;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done == '0 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // One operation from IDLE: launch, completion latency, response, IDLE gap.
  task automatic run_op(input string tag, input logic [3:0] rq, input logic [3:0] exp_g,
                        input int lat, input logic [255:0] exp_p, input bit hold);
    int c;
    req = rq;
    tick(1);
    chk({tag, ".gnt"}, 256'(gnt), 256'(exp_g));
    chk({tag, ".mrst_hi"}, 256'(mul_reset), 256'd1);
    if (!hold) req = 4'b0000;
    tick(1);
    chk({tag, ".mrst_lo"}, 256'(mul_reset), 256'd0);
    wait_done(c);
    chk({tag, ".lat"}, 256'(c), 256'(lat + 1));
    chk({tag, ".done"}, 256'(done), 256'(exp_g));
    chk({tag, ".prod"}, product, exp_p);
    chk({tag, ".err"}, 256'(err), 256'd0);
    tick(1);
    chk({tag, ".done_off"}, 256'(done), 256'd0);
    chk({tag, ".gap_gnt"}, 256'(gnt), 256'd0);
  endtask

  initial begin
    logic [255:0] half;
    int           c;
    bit           seen;
    Reset = 1'b1;
    req   = 4'b0000;
    a_i   = '0;
    b_i   = '0;
    tick(3);
    chk("rst.gnt", 256'(gnt), 256'd0);
    chk("rst.done", 256'(done), 256'd0);
    chk("rst.err", 256'(err), 256'd0);
    chk("rst.prod", product, 256'd0);
    chk("rst.mrst", 256'(mul_reset), 256'd1);
    Reset = 1'b0;
    tick(1);
    chk("idle.mrst", 256'(mul_reset), 256'd0);

    // Basic multiply on slot 1 with distractor operands elsewhere.
    a_i[0] = 256'd99; b_i[0] = 256'd98;
    a_i[1] = 256'd3;  b_i[1] = 256'd5;
    a_i[2] = 256'd77; b_i[2] = 256'd66;
    run_op("basic", 4'b0010, 4'b0010, 3, 256'd15, 1'b0);

    // Wrap-around products; pointer now 2 so slot 0 is reached by wrapping.
    a_i[0] = N_MOD - 256'd1; b_i[0] = N_MOD - 256'd1;
    run_op("wrap_nm1", 4'b0001, 4'b0001, 3, 256'd1, 1'b0);
    half   = (N_MOD + 256'd1) >> 1;
    a_i[2] = 256'd2; b_i[2] = half;
    run_op("wrap_half", 4'b0100, 4'b0100, 3, 256'd1, 1'b0);

    // Fairness: req 0101 held from reset gives 0,2,0,2 with a one-cycle gap.
    Reset = 1'b1; tick(2); Reset = 1'b0;
    a_i[0] = 256'd7;  b_i[0] = 256'd11;
    a_i[2] = 256'd13; b_i[2] = 256'd17;
    run_op("fair0", 4'b0101, 4'b0001, 3, 256'd77, 1'b1);
    run_op("fair1", 4'b0101, 4'b0100, 3, 256'd221, 1'b1);
    run_op("fair2", 4'b0101, 4'b0001, 3, 256'd77, 1'b1);
    run_op("fair3", 4'b0101, 4'b0100, 3, 256'd221, 1'b1);
    req = 4'b0000;

    // Stale Done: stub raises Done while idle and keeps it high.
    Reset = 1'b1; tick(2); Reset = 1'b0;
    stub_lat = 5;
    tick(10);
    chk("stale.idle_done", 256'(done), 256'd0);
    a_i[0] = 256'd21; b_i[0] = 256'd2;
    a_i[1] = 256'd6;  b_i[1] = 256'd9;
    run_op("stale0", 4'b0011, 4'b0001, 5, 256'd42, 1'b1);
    run_op("stale1", 4'b0011, 4'b0010, 5, 256'd54, 1'b1);
    req = 4'b0000;

    // Reset during WAIT aborts with no done; a fresh request then completes.
    stub_lat = 8;
    a_i[3] = 256'd4; b_i[3] = 256'd4;
    req = 4'b1000;
    tick(1);
    chk("midrst.gnt", 256'(gnt), 256'b1000);
    req = 4'b0000;
    tick(3);
    Reset = 1'b1;
    tick(1);
    chk("midrst.gnt0", 256'(gnt), 256'd0);
    chk("midrst.done0", 256'(done), 256'd0);
    chk("midrst.mrst", 256'(mul_reset), 256'd1);
    Reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (done != '0) seen = 1'b1;
    end
    chk("midrst.no_done", 256'(seen), 256'd0);
    stub_lat = 2;
    a_i[1] = 256'd10; b_i[1] = 256'd10;
    run_op("post_rst", 4'b0010, 4'b0010, 2, 256'd100, 1'b0);

    // Watchdog: Done never rises, err+done 17 cycles after the LAUNCH cycle.
    stub_never = 1'b1;
    a_i[3] = 256'd9; b_i[3] = 256'd9;
    req = 4'b1000;
    tick(1);
    chk("to.gnt", 256'(gnt), 256'b1000);
    req = 4'b0000;
    wait_done(c);
    chk("to.lat", 256'(c), 256'(TO + 1));
    chk("to.done", 256'(done), 256'b1000);
    chk("to.err", 256'(err), 256'd1);
    chk("to.prod", product, 256'd0);
    tick(1);
    chk("to.done_off", 256'(done), 256'd0);
    chk("to.err_off", 256'(err), 256'd0);
    stub_never = 1'b0;
    a_i[0] = 256'd5; b_i[0] = 256'd6;
    a_i[3] = 256'd8; b_i[3] = 256'd8;
    run_op("to_ptr", 4'b1001, 4'b0001, 2, 256'd30, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
